// File: rtl/mux4_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter_pkg
//   Shared definitions for the four-requester round-robin arbiter that owns
//   the select of the 4:1 single-bit mux.
//   Contents: arbiter FSM state encoding, requester count, select width.
// -----------------------------------------------------------------------------
package mux4_rr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

endpackage

// File: rtl/mux_4_1.sv
// -----------------------------------------------------------------------------
// mux_4_1
//   Existing 4:1 single-bit multiplexer, used unchanged by the arbiter.
//   Ports:
//     data [3:0] : data inputs, one bit per source
//     sel  [1:0] : source index
//     Y          : data[sel]
// -----------------------------------------------------------------------------
module mux_4_1 (
   input  logic [3:0] data,
   input  logic [1:0] sel,
   output logic       Y
);

   assign Y = data[sel];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter sharing mux_4_1 between four requesters. A grant lasts
//   until its requester drops req or MAX_HOLD cycles have elapsed; on release
//   the next winner is picked at the same edge starting after the released
//   requester, so there is no idle bubble under load.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     req   : request per requester (req[i] -> requester i)
//     data  : data bit per requester, routed through mux_4_1
//     gnt   : registered one-hot grant, zero when idle
//     sel   : registered index of granted requester, drives mux_4_1 sel
//     busy  : registered, high while a grant is active
//     y     : data[sel] when busy, else 0
// -----------------------------------------------------------------------------
module mux4_rr_arbiter
   import mux4_rr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] data,
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             y
);

   arb_state_t       state;
   logic [SEL_W-1:0] ptr;
   logic [CNT_W-1:0] hold_cnt;

   logic [SEL_W-1:0] search_base;
   logic [SEL_W:0]   win;
   logic             win_found;
   logic [SEL_W-1:0] win_idx;
   logic             release_now;
   logic             mux_y;

   // Returns {found, index} of the first asserted request in circular order
   // starting at base. Scanning offsets from high to low lets the smallest
   // offset overwrite the others, giving it priority.
   function automatic logic [SEL_W:0] find_winner(input logic [N_REQ-1:0] r,
                                                   input logic [SEL_W-1:0] base);
      logic [SEL_W:0]   result;
      logic [SEL_W-1:0] idx;
      result = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = base + SEL_W'(k);
         if (r[idx]) begin
            result = {1'b1, idx};
         end
      end
      return result;
   endfunction

   // In GRANT the only search that matters is the one at release, which
   // starts just after the current owner; that equals the pointer value the
   // release will write, so the new pointer is used before it is registered.
   assign search_base = (state == GRANT) ? sel + SEL_W'(1) : ptr;
   assign win         = find_winner(req, search_base);
   assign win_found   = win[SEL_W];
   assign win_idx     = win[SEL_W-1:0];
   assign release_now = (state == GRANT) &&
                        (!req[sel] || (hold_cnt == CNT_W'(MAX_HOLD - 1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         gnt      <= '0;
         sel      <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  gnt      <= N_REQ'(1) << win_idx;
                  sel      <= win_idx;
                  busy     <= 1'b1;
                  hold_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (release_now) begin
                  ptr      <= sel + SEL_W'(1);
                  hold_cnt <= '0;
                  if (win_found) begin
                     gnt <= N_REQ'(1) << win_idx;
                     sel <= win_idx;
                  end else begin
                     gnt   <= '0;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   mux_4_1 u_mux (
      .data (data),
      .sel  (sel),
      .Y    (mux_y)
   );

   assign y = busy & mux_y;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//   Directed scenarios plus randomized traffic against a behavioural model of
//   the round-robin grant rules.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

   localparam int MH = 4;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] data;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       y;

   int n_chk;
   int n_pass;

   // behavioural model state
   bit m_busy;
   int m_owner;
   int m_ptr;
   int m_held;

   mux4_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .data  (data),
      .gnt   (gnt),
      .sel   (sel),
      .busy  (busy),
      .y     (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
   endtask

   function automatic int search(input logic [3:0] r, input int start);
      for (int k = 0; k < 4; k++)
         if (r[(start + k) % 4]) return (start + k) % 4;
      return -1;
   endfunction

   task automatic model_reset();
      m_busy  = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      m_held  = 0;
   endtask

   // m_held counts cycles already spent in the current grant.
   task automatic model_edge(input logic [3:0] r);
      if (!m_busy) begin
         if (r != 4'b0) begin
            m_owner = search(r, m_ptr);
            m_busy  = 1'b1;
            m_held  = 1;
         end
      end else if (!r[m_owner] || m_held == MH) begin
         m_ptr = (m_owner + 1) % 4;
         if (r != 4'b0) begin
            m_owner = search(r, m_ptr);
            m_held  = 1;
         end else begin
            m_busy = 1'b0;
         end
      end else begin
         m_held++;
      end
   endtask

   task automatic check_model(input string tag);
      logic [3:0] eg;
      logic       ey;
      eg = m_busy ? 4'(1 << m_owner) : 4'b0;
      ey = m_busy ? data[m_owner] : 1'b0;
      chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
      chk({tag, "_busy"}, 32'(busy), 32'(m_busy));
      chk({tag, "_y"}, 32'(y), 32'(ey));
      if (m_busy) chk({tag, "_sel"}, 32'(sel), 32'(m_owner));
   endtask

   // One clock: model follows the req seen at the edge, outputs sampled 1 ns later.
   task automatic step(input string tag);
      logic [3:0] r;
      @(posedge clk);
      r = req;
      model_edge(r);
      #1;
      check_model(tag);
   endtask

   // Asynchronous reset asserted between edges, checked before any edge.
   task automatic do_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      chk({tag, "_rst_gnt"}, 32'(gnt), 32'h0);
      chk({tag, "_rst_sel"}, 32'(sel), 32'h0);
      chk({tag, "_rst_busy"}, 32'(busy), 32'h0);
      chk({tag, "_rst_y"}, 32'(y), 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      model_reset();
      rst_n = 1'b0;
      req   = 4'b0;
      data  = 4'b0;
      #3;
      chk("init_gnt", 32'(gnt), 32'h0);
      chk("init_sel", 32'(sel), 32'h0);
      chk("init_busy", 32'(busy), 32'h0);
      chk("init_y", 32'(y), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Sole requester: re-granted back-to-back across timeouts.
      req  = 4'b0100;
      data = 4'b0100;
      for (int i = 0; i < 10; i++) begin
         step("single");
         chk("single_gnt_const", 32'(gnt), 32'h4);
         chk("single_y_const", 32'(y), 32'h1);
      end
      req = 4'b0;
      step("single_end");

      // Full load: 4-cycle tenures rotating 0,1,2,3,0.
      do_reset("full");
      req  = 4'b1111;
      data = 4'b1010;
      for (int i = 0; i < 20; i++) begin
         step("full");
         chk("full_seq", 32'(gnt), 32'(1 << ((i / MH) % 4)));
         chk("full_busy", 32'(busy), 32'h1);
      end

      // Early release and hand-off at the same edge.
      do_reset("early");
      req = 4'b1010;
      step("early1");
      chk("early_first", 32'(gnt), 32'h2);
      step("early2");
      req = 4'b1000;
      step("early3");
      chk("early_handoff_gnt", 32'(gnt), 32'h8);
      chk("early_handoff_sel", 32'(sel), 32'h3);
      req = 4'b0000;
      step("early4");
      chk("early_idle_gnt", 32'(gnt), 32'h0);
      chk("early_idle_busy", 32'(busy), 32'h0);

      // Data path through the mux while requester 3 holds the grant.
      req = 4'b1000;
      step("dp_grant");
      for (int k = 0; k < 16; k++) begin
         data = 4'(k);
         #1;
         chk("dp_y_comb", 32'(y), 32'(k[3]));
         step("dp");
      end
      req = 4'b0;
      step("dp_rel");
      for (int k = 8; k < 16; k++) begin
         data = 4'(k);
         #1;
         chk("dp_y_idle", 32'(y), 32'h0);
      end

      // Reset in the middle of a grant to requester 2, then priority restarts at 0.
      do_reset("mid");
      req = 4'b1111;
      begin
         int guard;
         guard = 0;
         while (!(m_busy && m_owner == 2) && guard < 50) begin
            step("mid_run");
            guard++;
         end
         chk("mid_reach_owner2", 32'(guard < 50), 32'h1);
      end
      chk("mid_pre_gnt", 32'(gnt), 32'h4);
      do_reset("mid");
      step("mid_after");
      chk("mid_first_gnt", 32'(gnt), 32'h1);

      // Randomized traffic, with occasional asynchronous resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         data = 4'($urandom);
         if ($urandom_range(0, 199) == 0) do_reset("rnd");
         step("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
